system_reset_sequencer: RTL and testbench



---
 rtl/system_reset_pkg.sv | 20 ++
 rtl/system_reset_sequencer_if.sv | 28 ++
 rtl/reset_button_debounce.sv | 51 +++++
 rtl/system_reset_sequencer.sv | 119 +++++++++++
 tb/tb_system_reset_sequencer.sv | 166 ++++++++++++++++
 5 files changed

// File: rtl/system_reset_pkg.sv
// Shared types and helpers for the staged reset sequencer.
// Holds the sequencer state encoding and the counter-width helper.
package system_reset_pkg;

    typedef enum logic [1:0] {
        WAIT_LOCK  = 2'd0,
        PERIPH_RUN = 2'd1,
        RUN        = 2'd2
    } reset_seq_state_t;

    // Width able to hold the values 0..n inclusive.
    function automatic int counter_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

    localparam int LP_DEF_LOCK_STABLE = 1024;
    localparam int LP_DEF_STAGE_DELAY = 16;
    localparam int LP_DEF_DEBOUNCE    = 500000;

endpackage

// File: rtl/system_reset_sequencer_if.sv
// Board-facing signal bundle of the reset sequencer.
// Ports: iPLL_LOCK, iRESET_BUTTON_N (to sequencer); oRESET_PERIPH,
// oRESET_CORE, oSYSTEM_READY (from sequencer).
interface system_reset_sequencer_if;

    logic iPLL_LOCK;
    logic iRESET_BUTTON_N;
    logic oRESET_PERIPH;
    logic oRESET_CORE;
    logic oSYSTEM_READY;

    modport master (
        output iPLL_LOCK,
        output iRESET_BUTTON_N,
        input  oRESET_PERIPH,
        input  oRESET_CORE,
        input  oSYSTEM_READY
    );

    modport slave (
        input  iPLL_LOCK,
        input  iRESET_BUTTON_N,
        output oRESET_PERIPH,
        output oRESET_CORE,
        output oSYSTEM_READY
    );

endinterface

// File: rtl/reset_button_debounce.sv
// 2-FF synchronizer and debouncer for the active-low reset push-button.
// Ports: i_clk, i_rst (sync, active-high), i_button_n (async, bouncy),
// o_pressed (debounced, active-high "button pressed").
module reset_button_debounce
    import system_reset_pkg::*;
#(
    parameter int P_DEBOUNCE_CYCLES = LP_DEF_DEBOUNCE
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_button_n,
    output logic o_pressed
);

    localparam int LP_W = counter_width(P_DEBOUNCE_CYCLES);
    localparam logic [LP_W-1:0] LP_LAST = LP_W'(P_DEBOUNCE_CYCLES - 1);

    // Synchronizer carries the inverted (pressed) level so that its
    // cleared state already agrees with the "not pressed" output.
    logic            r_sync1;
    logic            r_sync2;
    logic            r_pressed;
    logic [LP_W-1:0] r_count;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync1   <= 1'b0;
            r_sync2   <= 1'b0;
            r_pressed <= 1'b0;
            r_count   <= '0;
        end else begin
            r_sync1 <= ~i_button_n;
            r_sync2 <= r_sync1;
            if (r_sync2 != r_pressed) begin
                // The differing sample on which the count hits its last
                // value completes the run and flips the output.
                if (r_count >= LP_LAST) begin
                    r_pressed <= r_sync2;
                    r_count   <= '0;
                end else begin
                    r_count <= r_count + 1'b1;
                end
            end else begin
                r_count <= '0;
            end
        end
    end

    assign o_pressed = r_pressed;

endmodule

// File: rtl/system_reset_sequencer.sv
// Staged reset generator: peripherals leave reset after a stable PLL lock,
// the core a fixed number of cycles later; lock loss or button re-enters
// full reset.
// Ports: iCLOCK, iRESET_SYNC (sync, active-high), bus (slave modport:
// iPLL_LOCK, iRESET_BUTTON_N in; oRESET_PERIPH, oRESET_CORE,
// oSYSTEM_READY out).
module system_reset_sequencer
    import system_reset_pkg::*;
#(
    parameter int P_LOCK_STABLE_CYCLES = LP_DEF_LOCK_STABLE,
    parameter int P_STAGE_DELAY        = LP_DEF_STAGE_DELAY,
    parameter int P_DEBOUNCE_CYCLES    = LP_DEF_DEBOUNCE
) (
    input  logic                    iCLOCK,
    input  logic                    iRESET_SYNC,
    system_reset_sequencer_if.slave bus
);

    localparam int LP_LOCK_W  = counter_width(P_LOCK_STABLE_CYCLES);
    localparam int LP_STAGE_W = counter_width(P_STAGE_DELAY);

    localparam logic [LP_LOCK_W-1:0] LP_LOCK_LAST =
        LP_LOCK_W'(P_LOCK_STABLE_CYCLES - 1);
    localparam logic [LP_STAGE_W-1:0] LP_STAGE_LAST =
        LP_STAGE_W'(P_STAGE_DELAY - 1);

    reset_seq_state_t       r_state;
    logic                   r_lock_meta;
    logic                   r_lock_s;
    logic [LP_LOCK_W-1:0]   r_stable_cnt;
    logic [LP_STAGE_W-1:0]  r_stage_cnt;
    logic                   r_reset_periph;
    logic                   r_reset_core;
    logic                   r_system_ready;

    logic                   w_btn_pressed;
    logic                   w_abort;
    reset_seq_state_t       w_next_state;
    logic [LP_LOCK_W-1:0]   w_stable_nxt;
    logic [LP_STAGE_W-1:0]  w_stage_nxt;

    reset_button_debounce #(
        .P_DEBOUNCE_CYCLES (P_DEBOUNCE_CYCLES)
    ) u_debounce (
        .i_clk      (iCLOCK),
        .i_rst      (iRESET_SYNC),
        .i_button_n (bus.iRESET_BUTTON_N),
        .o_pressed  (w_btn_pressed)
    );

    assign w_abort = ~r_lock_s | w_btn_pressed;

    always_comb begin
        w_next_state = r_state;
        w_stable_nxt = r_stable_cnt;
        w_stage_nxt  = r_stage_cnt;
        if (w_abort) begin
            w_next_state = WAIT_LOCK;
            w_stable_nxt = '0;
            w_stage_nxt  = '0;
        end else begin
            unique case (r_state)
                WAIT_LOCK: begin
                    if (r_stable_cnt == LP_LOCK_LAST) begin
                        w_next_state = PERIPH_RUN;
                        w_stable_nxt = '0;
                        w_stage_nxt  = '0;
                    end else if (r_stable_cnt < LP_LOCK_LAST) begin
                        w_stable_nxt = r_stable_cnt + 1'b1;
                    end
                end
                PERIPH_RUN: begin
                    if (r_stage_cnt == LP_STAGE_LAST) begin
                        w_next_state = RUN;
                    end else if (r_stage_cnt < LP_STAGE_LAST) begin
                        w_stage_nxt = r_stage_cnt + 1'b1;
                    end
                end
                RUN: begin
                    w_next_state = RUN;
                end
                default: begin
                    w_next_state = WAIT_LOCK;
                    w_stable_nxt = '0;
                    w_stage_nxt  = '0;
                end
            endcase
        end
    end

    // Outputs are decoded from the next state so they move on the same
    // edge as the state itself.
    always_ff @(posedge iCLOCK) begin
        if (iRESET_SYNC) begin
            r_state        <= WAIT_LOCK;
            r_lock_meta    <= 1'b0;
            r_lock_s       <= 1'b0;
            r_stable_cnt   <= '0;
            r_stage_cnt    <= '0;
            r_reset_periph <= 1'b1;
            r_reset_core   <= 1'b1;
            r_system_ready <= 1'b0;
        end else begin
            r_lock_meta    <= bus.iPLL_LOCK;
            r_lock_s       <= r_lock_meta;
            r_state        <= w_next_state;
            r_stable_cnt   <= w_stable_nxt;
            r_stage_cnt    <= w_stage_nxt;
            r_reset_periph <= (w_next_state == WAIT_LOCK);
            r_reset_core   <= (w_next_state != RUN);
            r_system_ready <= (w_next_state == RUN);
        end
    end

    assign bus.oRESET_PERIPH = r_reset_periph;
    assign bus.oRESET_CORE   = r_reset_core;
    assign bus.oSYSTEM_READY = r_system_ready;

endmodule

// File: tb/tb_system_reset_sequencer.sv
// Scoreboard bench for system_reset_sequencer: directed scenarios plus
// random lock/button/reset segments against a run-length reference model.
module tb_system_reset_sequencer;

    localparam int L = 8;
    localparam int S = 4;
    localparam int D = 5;

    typedef logic [2:0] exp_t;

    logic clk = 1'b0;
    logic rst;

    system_reset_sequencer_if bus ();

    system_reset_sequencer #(
        .P_LOCK_STABLE_CYCLES (L),
        .P_STAGE_DELAY        (S),
        .P_DEBOUNCE_CYCLES    (D)
    ) dut (
        .iCLOCK      (clk),
        .iRESET_SYNC (rst),
        .bus         (bus)
    );

    always #5 clk = ~clk;

    // Reference model: k counts consecutive edges without abort or reset;
    // peripherals are free once k reaches L, the core once k reaches L+S.
    int   m_k = 0;
    bit   m_sync1 = 0;
    bit   m_lock_s = 0;
    bit   m_b1 = 0;
    bit   m_b2 = 0;
    bit   m_deb = 0;
    bit   m_hist[$];
    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;

    task automatic model_edge(input bit r, input bit l, input bit bn);
        bit abort;
        bit all_diff;
        exp_t e;
        if (r) begin
            m_k = 0;
            m_sync1 = 0;
            m_lock_s = 0;
            m_b1 = 0;
            m_b2 = 0;
            m_deb = 0;
            m_hist.delete();
        end else begin
            abort = !m_lock_s || m_deb;
            m_k = abort ? 0 : m_k + 1;
            // Debounced level flips once the last D synchronized
            // samples all disagree with it.
            m_hist.push_back(m_b2);
            if (m_hist.size() > D) void'(m_hist.pop_front());
            all_diff = (m_hist.size() == D);
            foreach (m_hist[i]) if (m_hist[i] == m_deb) all_diff = 0;
            if (all_diff) begin
                m_deb = !m_deb;
                m_hist.delete();
            end
            m_lock_s = m_sync1;
            m_sync1 = l;
            m_b2 = m_b1;
            m_b1 = !bn;
        end
        e[2] = (m_k < L);
        e[1] = (m_k < L + S);
        e[0] = (m_k >= L + S);
        sb.push_back(e);
    endtask

    task automatic step(input bit r, input bit l, input bit bn);
        rst = r;
        bus.iPLL_LOCK = l;
        bus.iRESET_BUTTON_N = bn;
        @(posedge clk);
        model_edge(r, l, bn);
        #1;
    endtask

    task automatic run(input bit r, input bit l, input bit bn, input int n);
        repeat (n) step(r, l, bn);
    endtask

    initial begin
        exp_t e;
        exp_t a;
        forever begin
            @(negedge clk);
            cyc++;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                a = {bus.oRESET_PERIPH, bus.oRESET_CORE, bus.oSYSTEM_READY};
                n_cmp++;
                if (a !== e) begin
                    n_bad++;
                    $display("FAIL outputs cyc %0d: periph/core/ready got %b want %b",
                             cyc, a, e);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int len;
        bit r;
        bit l;
        bit bn;
        // Reset, then release with lock already high.
        run(1, 0, 1, 3);
        run(1, 1, 1, 2);
        run(0, 1, 1, 20);
        // Lock glitch during the stable count.
        run(0, 0, 1, 5);
        run(0, 1, 1, 5);
        run(0, 0, 1, 1);
        run(0, 1, 1, 20);
        // Lock loss in RUN, then recovery.
        run(0, 0, 1, 4);
        run(0, 1, 1, 20);
        // Short bounce, then a real press and release.
        run(0, 1, 0, 3);
        run(0, 1, 1, 6);
        run(0, 1, 0, 10);
        run(0, 1, 1, 25);
        // Sync reset pulse inside PERIPH_RUN.
        run(0, 0, 1, 3);
        run(0, 1, 1, 11);
        run(1, 1, 1, 1);
        run(0, 1, 1, 20);
        // Lock loss and button press together in RUN.
        run(0, 0, 0, 8);
        run(0, 1, 1, 30);
        // Random segments.
        repeat (80) begin
            r   = ($urandom_range(0, 19) == 0);
            l   = ($urandom_range(0, 5) != 0);
            bn  = ($urandom_range(0, 4) != 0);
            len = $urandom_range(1, 24);
            run(r, l, bn, len);
        end
        run(0, 1, 1, 2);
        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d entries left, want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
